// File: rtl/sv32_pkg.sv
// Shared Sv32 walker definitions: PTE layout and bit indices, walk states, fault codes.
// No logic here. Imported by the walker FSM and by the PTE checker.
package sv32_pkg;

    localparam int PTE_V = 0;
    localparam int PTE_R = 1;
    localparam int PTE_W = 2;
    localparam int PTE_X = 3;
    localparam int PTE_U = 4;
    localparam int PTE_G = 5;
    localparam int PTE_A = 6;
    localparam int PTE_D = 7;

    localparam logic [3:0] EXC_LD_ACC = 4'd5;
    localparam logic [3:0] EXC_ST_ACC = 4'd7;
    localparam logic [3:0] EXC_LD_PF  = 4'd13;
    localparam logic [3:0] EXC_ST_PF  = 4'd15;

    typedef enum logic [2:0] {
        S_IDLE,
        S_L1_REQ,
        S_L1_WAIT,
        S_L0_REQ,
        S_L0_WAIT,
        S_DONE,
        S_DRAIN
    } walk_state_e;

    typedef struct packed {
        logic [11:0] ppn1;
        logic [9:0]  ppn0;
        logic [1:0]  rsw;
        logic        d;
        logic        a;
        logic        g;
        logic        u;
        logic        x;
        logic        w;
        logic        r;
        logic        v;
    } pte_t;

    function automatic logic [3:0] exc_code(input logic is_write, input logic page_fault);
        if (page_fault) begin
            return is_write ? EXC_ST_PF : EXC_LD_PF;
        end
        return is_write ? EXC_ST_ACC : EXC_LD_ACC;
    endfunction

endpackage

// File: rtl/sv32_pte_check.sv
// Combinational PTE evaluation for one walk level: leaf detection, fault and fault code.
// Zero latency, no flow control; the walker decides when the result is used.
module sv32_pte_check
    import sv32_pkg::*;
#(
    parameter int CHECK_AD = 1
) (
    input  logic [31:0] i_pte,
    input  logic        i_level,
    input  logic        i_is_write,
    input  logic        i_err,
    output logic        o_leaf,
    output logic        o_fault,
    output logic [3:0]  o_code
);

    pte_t w_pte;
    logic w_leaf;
    logic w_unused_bits;

    assign w_pte         = i_pte;
    assign w_leaf        = w_pte.r | w_pte.x;
    assign o_leaf        = w_leaf;
    assign w_unused_bits = ^{w_pte.ppn1, w_pte.rsw, w_pte.g, w_pte.u};

    // Checks are ordered by priority; the first match sets the code.
    always_comb begin
        o_fault = 1'b0;
        o_code  = exc_code(i_is_write, 1'b1);
        if (i_err) begin
            o_fault = 1'b1;
            o_code  = exc_code(i_is_write, 1'b0);
        end else if (!w_pte.v || (!w_pte.r && w_pte.w)) begin
            o_fault = 1'b1;
        end else if (w_leaf && i_level && (w_pte.ppn0 != 10'd0)) begin
            o_fault = 1'b1;
        end else if (w_leaf && (CHECK_AD != 0) && (!w_pte.a || (i_is_write && !w_pte.d))) begin
            o_fault = 1'b1;
        end else if (!w_leaf && !i_level) begin
            o_fault = 1'b1;
        end
    end

endmodule

// File: rtl/sv32_page_walker.sv
// Sv32 two-level page-table walker serving dtlb misses; one PTE read outstanding at a time.
// Zero-wait memory gives a response 3 cycles (superpage) or 5 cycles (4 KiB) after the request.
module sv32_page_walker
    import sv32_pkg::*;
#(
    parameter int CHECK_AD   = 1,
    parameter int ROOT_PPN_W = 20
) (
    input  logic                  cpu_clk_i,
    input  logic                  cpu_rst_i,
    input  logic                  flush_i,
    input  logic [ROOT_PPN_W-1:0] satp_ppn_i,
    input  logic [19:0]           vpn_i,
    input  logic                  vpn_vld_i,
    input  logic                  isWrite_i,
    output logic                  resp_vld_o,
    output logic                  is_superpage_o,
    output logic [31:0]           assoc_pte_o,
    output logic [3:0]            excp_code_o,
    output logic                  excp_vld_o,
    output logic                  mem_req_o,
    output logic [31:0]           mem_addr_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic [31:0]           mem_rdata_i,
    input  logic                  mem_err_i
);

    walk_state_e           r_state;
    walk_state_e           w_next;
    logic [19:0]           r_vpn;
    logic                  r_is_write;
    logic [ROOT_PPN_W-1:0] r_root;
    logic [31:0]           r_pte;
    logic                  r_super;
    logic                  r_excp_vld;
    logic [3:0]            r_code;

    logic                  w_start;
    logic                  w_eval;
    logic                  w_level;
    logic                  w_leaf;
    logic                  w_fault;
    logic [3:0]            w_code;
    logic [19:0]           w_root20;

    assign w_root20 = 20'(r_root);
    assign w_level  = (r_state == S_L1_WAIT);
    assign w_start  = (r_state == S_IDLE) && vpn_vld_i && !flush_i;
    assign w_eval   = ((r_state == S_L1_WAIT) || (r_state == S_L0_WAIT)) && mem_rvalid_i && !flush_i;

    sv32_pte_check #(
        .CHECK_AD (CHECK_AD)
    ) u_check (
        .i_pte      (mem_rdata_i),
        .i_level    (w_level),
        .i_is_write (r_is_write),
        .i_err      (mem_err_i),
        .o_leaf     (w_leaf),
        .o_fault    (w_fault),
        .o_code     (w_code)
    );

    always_ff @(posedge cpu_clk_i or posedge cpu_rst_i) begin
        if (cpu_rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        mem_req_o  = 1'b0;
        mem_addr_o = 32'd0;
        resp_vld_o = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start) w_next = S_L1_REQ;
            end
            S_L1_REQ, S_L0_REQ: begin
                mem_req_o  = 1'b1;
                mem_addr_o = (r_state == S_L1_REQ) ? {w_root20, r_vpn[19:10], 2'b00}
                                                   : {r_pte[29:10], r_vpn[9:0], 2'b00};
                // A granted read must still be drained even when flushed.
                if (flush_i) begin
                    w_next = mem_gnt_i ? S_DRAIN : S_IDLE;
                end else if (mem_gnt_i) begin
                    w_next = (r_state == S_L1_REQ) ? S_L1_WAIT : S_L0_WAIT;
                end
            end
            S_L1_WAIT, S_L0_WAIT: begin
                if (flush_i) begin
                    w_next = mem_rvalid_i ? S_IDLE : S_DRAIN;
                end else if (mem_rvalid_i) begin
                    if (w_level && !w_fault && !w_leaf) begin
                        w_next = S_L0_REQ;
                    end else begin
                        w_next = S_DONE;
                    end
                end
            end
            S_DONE: begin
                resp_vld_o = 1'b1;
                w_next     = S_IDLE;
            end
            S_DRAIN: begin
                if (mem_rvalid_i) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // r_pte holds the L1 pointer during the L0 read, then the leaf.
    always_ff @(posedge cpu_clk_i or posedge cpu_rst_i) begin
        if (cpu_rst_i) begin
            r_vpn      <= '0;
            r_is_write <= 1'b0;
            r_root     <= '0;
            r_pte      <= '0;
            r_super    <= 1'b0;
            r_excp_vld <= 1'b0;
            r_code     <= '0;
        end else begin
            if (w_start) begin
                r_vpn      <= vpn_i;
                r_is_write <= isWrite_i;
                r_root     <= satp_ppn_i;
            end
            if (w_eval) begin
                r_pte      <= mem_rdata_i;
                r_excp_vld <= w_fault;
                r_code     <= w_fault ? w_code : 4'd0;
                r_super    <= !w_fault && w_leaf && w_level;
            end
        end
    end

    assign assoc_pte_o    = r_pte;
    assign is_superpage_o = r_super;
    assign excp_vld_o     = r_excp_vld;
    assign excp_code_o    = r_code;

endmodule
